// File: rtl/wb_stage_if.sv
// MEM -> WB stage bundle.
// Carries the memory-stage results and control into the write-back stage,
// and the register-file write port plus status back out of it.
//   master : the MEM side (drives instruction data/control, observes WB outputs)
//   slave  : the WB stage (consumes instruction data/control, drives WB outputs)
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  // MEM -> WB
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [31:0]      alu_res;
  logic [31:0]      mem_rdata;
  logic [31:0]      pc_plus4;
  logic [1:0]       wb_sel;
  logic [2:0]       ld_type;
  logic [4:0]       rd;
  logic             reg_wr;
  // WB -> register file / status
  logic [4:0]       Rw;
  logic [31:0]      Di;
  logic             WE;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output in_valid, stall, flush, alu_res, mem_rdata, pc_plus4,
           wb_sel, ld_type, rd, reg_wr,
    input  Rw, Di, WE, wb_valid, retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush, alu_res, mem_rdata, pc_plus4,
           wb_sel, ld_type, rd, reg_wr,
    output Rw, Di, WE, wb_valid, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back value formatting.
// Selects ALU / load / link data, extracts and extends sub-word loads, and
// registers the result onto the register-file write port. All outputs are
// straight from flops, so they settle after posedge and are stable for the
// register file's negedge write.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mem_wb     : wb_stage_if.slave bundle (inputs from MEM, Rw/Di/WE,
//                wb_valid, retire_cnt outputs)
// Priority each edge: rst > flush > stall > capture.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  mem_wb
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [4:0]       rw_q,  rw_d;
  logic [31:0]      di_q,  di_d;
  logic             we_q,  we_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ld_val;
  logic [31:0] wb_val;

  // Load extraction: lane chosen by the low address bits; halfwords ignore
  // alu_res[0] (no misalignment trap).
  always_comb begin
    byte_lane = mem_wb.mem_rdata[7:0];
    case (mem_wb.alu_res[1:0])
      2'd0: byte_lane = mem_wb.mem_rdata[7:0];
      2'd1: byte_lane = mem_wb.mem_rdata[15:8];
      2'd2: byte_lane = mem_wb.mem_rdata[23:16];
      2'd3: byte_lane = mem_wb.mem_rdata[31:24];
      default: byte_lane = mem_wb.mem_rdata[7:0];
    endcase
    half_lane = mem_wb.alu_res[1] ? mem_wb.mem_rdata[31:16]
                                  : mem_wb.mem_rdata[15:0];
    case (mem_wb.ld_type)
      LD_LB:   ld_val = {{24{byte_lane[7]}}, byte_lane};
      LD_LBU:  ld_val = {24'd0, byte_lane};
      LD_LH:   ld_val = {{16{half_lane[15]}}, half_lane};
      LD_LHU:  ld_val = {16'd0, half_lane};
      LD_LW:   ld_val = mem_wb.mem_rdata;
      default: ld_val = mem_wb.mem_rdata;  // undefined encodings act as LW
    endcase
    case (mem_wb.wb_sel)
      2'b01:   wb_val = ld_val;
      2'b10:   wb_val = mem_wb.pc_plus4;
      default: wb_val = mem_wb.alu_res;    // 00 and 11
    endcase
  end

  // Next-state: flush beats stall; a bubble keeps Rw/Di so the write port
  // address/data do not toggle needlessly.
  always_comb begin
    rw_d  = rw_q;
    di_d  = di_q;
    we_d  = we_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (mem_wb.flush) begin
      rw_d  = '0;
      di_d  = '0;
      we_d  = 1'b0;
      vld_d = 1'b0;
    end else if (!mem_wb.stall) begin
      if (mem_wb.in_valid) begin
        rw_d  = mem_wb.rd;
        di_d  = wb_val;
        // r0 writes are dropped but the instruction still retires
        we_d  = mem_wb.reg_wr && (mem_wb.rd != 5'd0);
        vld_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end else begin
        we_d  = 1'b0;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q  <= '0;
      di_q  <= '0;
      we_q  <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rw_q  <= rw_d;
      di_q  <= di_d;
      we_q  <= we_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign mem_wb.Rw         = rw_q;
  assign mem_wb.Di         = di_q;
  assign mem_wb.WE         = we_q;
  assign mem_wb.wb_valid   = vld_q;
  assign mem_wb.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(CNT_W)) bus ();

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_wb (bus)
  );

  // Register file: writes on negedge from the stage's registered port.
  logic [31:0] rf [32];
  always @(negedge clk) if (bus.WE && bus.Rw != 5'd0) rf[bus.Rw] <= bus.Di;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [4:0]  m_rw;
  logic [31:0] m_di;
  logic        m_we, m_vld;
  int          m_cnt;

  function automatic logic [31:0] ref_fmt(input logic [1:0] sel, input logic [2:0] lt,
                                          input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] pc);
    longint v;
    int     sh;
    if (sel == 2'd2) return pc;
    if (sel != 2'd1) return alu;
    if (lt == 3'd1 || lt == 3'd3) begin
      sh = 8 * int'(alu % 4);
      v  = longint'((mem >> sh) % 256);
      if (lt == 3'd1 && v >= 128) v = v - 256;
      return v[31:0];
    end
    if (lt == 3'd2 || lt == 3'd4) begin
      sh = 16 * int'((alu / 2) % 2);
      v  = longint'((mem >> sh) % 65536);
      if (lt == 3'd2 && v >= 32768) v = v - 65536;
      return v[31:0];
    end
    return mem;
  endfunction

  task automatic model();
    if (rst) begin
      m_rw = 0; m_di = 0; m_we = 0; m_vld = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_rw = 0; m_di = 0; m_we = 0; m_vld = 0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        m_rw  = bus.rd;
        m_di  = ref_fmt(bus.wb_sel, bus.ld_type, bus.alu_res, bus.mem_rdata, bus.pc_plus4);
        m_we  = bus.reg_wr && bus.rd != 0;
        m_vld = 1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_we = 0; m_vld = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("Rw", 32'(bus.Rw), 32'(m_rw));
    chk("Di", bus.Di, m_di);
    chk("WE", 32'(bus.WE), 32'(m_we));
    chk("wb_valid", 32'(bus.wb_valid), 32'(m_vld));
    chk("retire_cnt", 32'(bus.retire_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc);
    bus.in_valid = v;  bus.rd = rd;  bus.reg_wr = wr;  bus.wb_sel = sel;
    bus.ld_type = lt;  bus.alu_res = alu;  bus.mem_rdata = mem;  bus.pc_plus4 = pc;
  endtask

  typedef struct { logic [2:0] lt; logic [31:0] alu; logic [31:0] di; } ld_case_t;
  ld_case_t ld_tab [5];

  initial begin
    ld_tab[0] = '{3'd1, 32'h102, 32'hFFFFFFFF};
    ld_tab[1] = '{3'd3, 32'h103, 32'h00000080};
    ld_tab[2] = '{3'd2, 32'h102, 32'hFFFF80FF};
    ld_tab[3] = '{3'd4, 32'h100, 32'h00007F01};
    ld_tab[4] = '{3'd0, 32'h101, 32'h80FF7F01};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    m_rw = 0; m_di = 0; m_we = 0; m_vld = 0; m_cnt = 0;

    // Reset held with a live writing instruction present
    rst = 1; bus.stall = 0; bus.flush = 0;
    drive(1, 5'd5, 1, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0);
    step(); step();
    chk("rst_Rw", 32'(bus.Rw), 32'd0);
    chk("rst_cnt", 32'(bus.retire_cnt), 32'd0);
    rst = 0;
    step();
    chk("post_rst_Rw", 32'(bus.Rw), 32'd5);
    chk("post_rst_WE", 32'(bus.WE), 32'd1);
    chk("post_rst_cnt", 32'(bus.retire_cnt), 32'd1);

    // Load extraction, directed
    foreach (ld_tab[i]) begin
      drive(1, 5'd3, 1, 2'd1, ld_tab[i].lt, ld_tab[i].alu, 32'h80FF7F01, 32'h0);
      step();
      chk("load_Di", bus.Di, ld_tab[i].di);
      chk("load_WE", 32'(bus.WE), 32'd1);
    end

    // r0 suppression, then link select
    drive(1, 5'd0, 1, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    step();
    chk("r0_WE", 32'(bus.WE), 32'd0);
    chk("r0_valid", 32'(bus.wb_valid), 32'd1);
    drive(1, 5'd31, 1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h400010);
    step();
    chk("link_Di", bus.Di, 32'h400010);
    chk("link_Rw", 32'(bus.Rw), 32'd31);

    // Stall freezes everything, then stall+flush gives a bubble
    drive(1, 5'd7, 1, 2'd0, 3'd0, 32'hA5, 32'h0, 32'h0);
    step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 10), 1, 2'd2, 3'd0, $urandom, $urandom, $urandom);
      step();
      chk("stall_Di", bus.Di, 32'hA5);
      chk("stall_Rw", 32'(bus.Rw), 32'd7);
    end
    bus.flush = 1;
    step();
    chk("flush_Di", bus.Di, 32'h0);
    chk("flush_WE", 32'(bus.WE), 32'd0);
    bus.stall = 0; bus.flush = 0;

    // Bubble keeps Rw/Di
    drive(1, 5'd12, 1, 2'd0, 3'd0, 32'hC0DE, 32'h0, 32'h0);
    step();
    drive(0, 5'd13, 1, 2'd0, 3'd0, 32'hBAD, 32'h0, 32'h0);
    step();
    chk("bubble_Di", bus.Di, 32'hC0DE);
    chk("bubble_WE", 32'(bus.WE), 32'd0);

    // Counter wrap: 16 captures from reset return to zero
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 5'(i), 1, 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
      step();
    end
    chk("wrap_cnt", 32'(bus.retire_cnt), 32'd0);

    // Register file integration
    drive(1, 5'd9, 1, 2'd0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    drive(0, 5'd0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("rf_busA", rf[9], 32'hDEADBEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), 2'($urandom),
            3'($urandom), $urandom, $urandom, $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back data formatting for the pipeline CPU.
- Captures memory-stage results and selects and formats the write-back value.
- Drives the register file write port (Rw, Di, WE) from registered outputs. They change only on posedge clk, so they are stable when the register file writes on negedge clk of the same cycle.
- Supports stall (hold), flush (bubble) and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retire_cnt; wraps modulo 2^CNT_W

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  MEM stage holds a real instruction this cycle
stall  input  1  hold all stage state
flush  input  1  squash this stage (insert bubble)
alu_res  input  32  ALU result; also the memory byte address for loads
mem_rdata  input  32  raw aligned word read from data memory
pc_plus4  input  32  link value for jal/jalr
wb_sel  input  2  00 ALU, 01 memory, 10 pc_plus4, 11 treated as ALU
ld_type  input  3  000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU; 101-111 treated as LW
rd  input  5  destination register number
reg_wr  input  1  instruction writes rd
Rw  output  5  register file write address
Di  output  32  register file write data
WE  output  1  register file write enable
wb_valid  output  1  stage holds a valid instruction
retire_cnt  output  CNT_W  count of instructions that passed through the stage

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: Rw=0, Di=0, WE=0, wb_valid=0, retire_cnt=0.
- Priority at each posedge: rst > flush > stall > capture.
- Flush:
  - Rw=0, Di=0, WE=0, wb_valid=0.
  - retire_cnt unchanged.
  - Flush together with stall: flush wins.
- Stall (no flush):
  - All outputs and retire_cnt hold.
  - Inputs are ignored.
- Capture with in_valid=1:
  - Rw=rd.
  - Di=formatted value (see below).
  - WE = reg_wr & (rd != 0). A write to r0 is suppressed, but the instruction still retires.
  - wb_valid=1.
  - retire_cnt += 1, wrapping from all-ones to 0.
- Capture with in_valid=0:
  - WE=0, wb_valid=0.
  - Rw and Di hold their previous values.
  - retire_cnt unchanged.
- Latency: inputs sampled at posedge k are visible on Rw/Di/WE right after posedge k. The register file consumes them at the negedge in cycle k. WE is high for exactly one cycle per captured writing instruction unless stalled; a stall repeats the same write, which is harmless.
- Data formatting (combinational on the inputs, then registered):
  - wb_sel 00/11: Di=alu_res.
  - wb_sel 10: Di=pc_plus4.
  - wb_sel 01: load extraction from mem_rdata:
    - LW: full word; alu_res[1:0] ignored.
    - LB/LBU: byte lane = alu_res[1:0] (0 → bits 7:0, 3 → bits 31:24). LB sign-extends from bit 7 of the lane; LBU zero-extends.
    - LH/LHU: half lane = alu_res[1] (0 → bits 15:0, 1 → bits 31:16). alu_res[0] is ignored; there is no misalignment trap. LH sign-extends; LHU zero-extends.
- Reset during a stall or flush: reset wins and all outputs take their reset values on that edge.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, reg_wr=1, rd=5 → Rw=0, Di=0, WE=0, wb_valid=0, retire_cnt=0. Release rst → next edge gives Rw=5, WE=1, retire_cnt=1.
- Load extraction: mem_rdata=32'h80FF7F01, wb_sel=01, rd=3. Expected Di per case:
  - LB, alu_res=..02 → Di=32'hFFFFFFFF.
  - LBU, alu_res=..03 → Di=32'h00000080.
  - LH, alu_res=..02 → Di=32'hFFFF80FF.
  - LHU, alu_res=..00 → Di=32'h00007F01.
  - LW → Di=32'h80FF7F01.
  - Each case: WE=1 after one edge.
- r0 and source select: rd=0, reg_wr=1, wb_sel=00, alu_res=32'h1234 → WE=0, wb_valid=1, retire_cnt increments. Then rd=31, wb_sel=10, pc_plus4=32'h400010 → Di=32'h400010, Rw=31, WE=1.
- Stall and flush:
  - Capture rd=7, Di=32'hA5, then stall=1 for 3 cycles with changing inputs → outputs and retire_cnt frozen.
  - Stall=1 and flush=1 together → WE=0, wb_valid=0, Rw=0, Di=0.
- Bubble and counter wrap (CNT_W=4):
  - in_valid=0 cycle → WE=0, Rw/Di unchanged, count unchanged.
  - 16 valid captures from reset → retire_cnt returns to 0.
- Integration with the register file: write 32'hDEADBEEF to r9 through this stage, then read Ra=9 two cycles later → busA=32'hDEADBEEF.
